// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encodings, widths, defaults and one-hot helper for the UART scheduler
package uart_tx_sched_pkg;
  localparam int BYTE_W = 8;
  localparam int SCHED_STATE_W = 2;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [SCHED_STATE_W-1:0] {
    UART_SCHED_IDLE     = 2'd0,
    UART_SCHED_START    = 2'd1,
    UART_SCHED_WAIT_END = 2'd2
  } sched_state_t;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
  endfunction
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// uart_tx_sched_rr_pick: combinational round-robin priority encoder scanning upward from last_grant+1
module uart_tx_sched_rr_pick #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  win,
  output logic          any
);
  always_comb begin
    logic [IW-1:0] j;
    logic found;
    win = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last_grant) + k) % N);
      if (valid[j] && !found) begin
        win[j] = 1'b1;
        found = 1'b1;
      end
    end
    any = |valid;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NREQ requesters, with watchdog
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          grant,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_end,
  output logic                     sched_busy,
  output logic                     timeout_err
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  sched_state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, ready_q, ready_d, done_q, done_d, win;
  logic [IW-1:0] last_q, last_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, pick_data;
  logic tx_start_q, tx_start_d, err_q, err_d, busy_q, busy_d, any;
  uart_tx_sched_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid(req_valid), .last_grant(last_q), .win(win), .any(any)
  );
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) if (win[i]) pick_data = req_data[i*BYTE_W +: BYTE_W];
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    wd_d = wd_q + 1'b1;
    tx_start_d = 1'b0;
    tx_data_d = '0;
    ready_d = '0;
    done_d = '0;
    err_d = 1'b0;
    if (state_q == UART_SCHED_IDLE) begin
      wd_d = '0;
      if (any && !tx_busy) begin
        state_d = UART_SCHED_START;
        grant_d = win;
        tx_start_d = 1'b1;
        tx_data_d = pick_data;
        ready_d = win;
      end
    end else if (state_q == UART_SCHED_START) begin
      state_d = UART_SCHED_WAIT_END;
    end else if (tx_end || wd_q == CNT_W'(TIMEOUT - 1)) begin
      state_d = UART_SCHED_IDLE;
      grant_d = '0;
      last_d = IW'(oh2idx(8'(grant_q)));
      done_d = tx_end ? grant_q : '0;
      err_d = !tx_end;
    end
    busy_d = state_d != UART_SCHED_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UART_SCHED_IDLE;
      grant_q <= '0;
      last_q <= IW'(NREQ - 1);
      wd_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      ready_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      wd_q <= wd_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
      ready_q <= ready_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end
  assign req_ready = ready_q;
  assign req_done = done_q;
  assign grant = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign sched_busy = busy_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for the UART transmit scheduler
module tb_uart_tx_sched;
  logic clk = 1'b0, reset = 1'b1, tx_busy = 1'b0, tx_end = 1'b0;
  logic [1:0] req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0] d_ready, d_done, d_grant, w_ready, w_done, w_grant;
  logic [7:0] d_data, w_data;
  logic d_start, d_busy, d_err, w_start, w_busy, w_err;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  uart_tx_sched u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(d_ready), .req_done(d_done), .grant(d_grant), .tx_start(d_start),
    .tx_data(d_data), .tx_busy(tx_busy), .tx_end(tx_end), .sched_busy(d_busy),
    .timeout_err(d_err)
  );
  uart_tx_sched #(.NREQ(2), .TIMEOUT(16), .CNT_W(5)) u_wd (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(w_ready), .req_done(w_done), .grant(w_grant), .tx_start(w_start),
    .tx_data(w_data), .tx_busy(tx_busy), .tx_end(tx_end), .sched_busy(w_busy),
    .timeout_err(w_err)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_end = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if ({d_ready, d_done, d_grant, d_start, d_data, d_busy, d_err} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", {d_ready, d_done, d_grant, d_start, d_data, d_busy, d_err});
    end
  endtask
  task automatic test_single();
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h0041;
    tick();
    tests++;
    if ({d_start, d_data, d_ready, d_grant, d_busy} !== {1'b1, 8'h41, 2'b01, 2'b01, 1'b1}) begin
      fails++;
      $display("FAIL single_start got start=%b data=%h ready=%b grant=%b busy=%b want 1 41 01 01 1", d_start, d_data, d_ready, d_grant, d_busy);
    end
    req_valid = 2'b00;
    tick();
    tests++;
    if ({d_start, d_data, d_ready, d_grant} !== {1'b0, 8'h00, 2'b00, 2'b01}) begin
      fails++;
      $display("FAIL single_after_start got start=%b data=%h ready=%b grant=%b want 0 00 00 01", d_start, d_data, d_ready, d_grant);
    end
    tick(19);
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
    tests++;
    if ({d_done, d_grant, d_busy, d_err} !== {2'b01, 2'b00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL single_done got done=%b grant=%b busy=%b err=%b want 01 00 0 0", d_done, d_grant, d_busy, d_err);
    end
    tick();
    tests++;
    if (d_done !== 2'b00) begin
      fails++;
      $display("FAIL single_done_pulse got %b want 00", d_done);
    end
  endtask
  task automatic test_fairness();
    logic [7:0] exp_data[4] = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    int last_start = -1, cnt;
    do_reset();
    req_valid = 2'b11;
    req_data = 16'h55AA;
    for (int n = 0; n < 4; n++) begin
      cnt = 0;
      while (!d_start && cnt < 20) begin
        tick();
        cnt++;
      end
      tests++;
      if (!d_start) begin
        fails++;
        $display("FAIL fair_start_timeout transfer %0d got no tx_start want tx_start", n);
        return;
      end
      if (d_data !== exp_data[n]) begin
        fails++;
        $display("FAIL fair_data transfer %0d got %h want %h", n, d_data, exp_data[n]);
      end
      if (last_start >= 0) begin
        tests++;
        if (cyc - last_start != 11) begin
          fails++;
          $display("FAIL fair_spacing transfer %0d got %0d want 11", n, cyc - last_start);
        end
      end
      last_start = cyc;
      tick(9);
      tx_end = 1'b1;
      tick();
      tx_end = 1'b0;
      tests++;
      if (d_done !== (n % 2 == 0 ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL fair_done transfer %0d got %b want %b", n, d_done, n % 2 == 0 ? 2'b01 : 2'b10);
      end
    end
  endtask
  task automatic test_busy_block();
    int early = 0;
    do_reset();
    tx_busy = 1'b1;
    req_valid = 2'b10;
    req_data = 16'h5A00;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (d_start || d_grant != 2'b00) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL busy_block got %0d start/grant cycles want 0", early);
    end
    tx_busy = 1'b0;
    tick();
    tests++;
    if ({d_start, d_data, d_ready, d_grant} !== {1'b1, 8'h5A, 2'b10, 2'b10}) begin
      fails++;
      $display("FAIL busy_release got start=%b data=%h ready=%b grant=%b want 1 5a 10 10", d_start, d_data, d_ready, d_grant);
    end
  endtask
  task automatic test_timeout();
    int early = 0;
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h2211;
    tick();
    tests++;
    if ({w_start, w_data, w_grant} !== {1'b1, 8'h11, 2'b01}) begin
      fails++;
      $display("FAIL to_start got start=%b data=%h grant=%b want 1 11 01", w_start, w_data, w_grant);
    end
    req_valid = 2'b11;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (w_err || w_grant != 2'b01) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL to_early got %0d bad cycles want 0", early);
    end
    tick();
    tests++;
    if ({w_err, w_done, w_grant, w_busy} !== {1'b1, 2'b00, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL to_abort got err=%b done=%b grant=%b busy=%b want 1 00 00 0", w_err, w_done, w_grant, w_busy);
    end
    tick();
    tests++;
    if ({w_start, w_data, w_grant, w_err} !== {1'b1, 8'h22, 2'b10, 1'b0}) begin
      fails++;
      $display("FAIL to_next_grant got start=%b data=%h grant=%b err=%b want 1 22 10 0", w_start, w_data, w_grant, w_err);
    end
  endtask
  task automatic test_collision();
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h0033;
    tick();
    req_valid = 2'b00;
    tick(15);
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
    tests++;
    if ({w_done, w_err, w_grant} !== {2'b01, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL collision got done=%b err=%b grant=%b want 01 0 00", w_done, w_err, w_grant);
    end
    tick();
    tests++;
    if (w_err !== 1'b0) begin
      fails++;
      $display("FAIL collision_late_err got %b want 0", w_err);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    req_valid = 2'b10;
    req_data = 16'h7700;
    tick();
    req_valid = 2'b00;
    tick(3);
    reset = 1'b1;
    tick();
    tests++;
    if ({d_ready, d_done, d_grant, d_start, d_data, d_busy, d_err} !== 16'h0) begin
      fails++;
      $display("FAIL midreset_outputs got %h want 0", {d_ready, d_done, d_grant, d_start, d_data, d_busy, d_err});
    end
    reset = 1'b0;
    req_valid = 2'b11;
    req_data = 16'h2211;
    tick();
    tests++;
    if ({d_start, d_data, d_grant} !== {1'b1, 8'h11, 2'b01}) begin
      fails++;
      $display("FAIL midreset_first got start=%b data=%h grant=%b want 1 11 01", d_start, d_data, d_grant);
    end
  endtask
  task automatic test_stray_end();
    do_reset();
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
    tick();
    tests++;
    if ({d_done, d_err, d_busy} !== 4'b0) begin
      fails++;
      $display("FAIL stray_end got done=%b err=%b busy=%b want 00 0 0", d_done, d_err, d_busy);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_busy_block();
    test_timeout();
    test_collision();
    test_mid_reset();
    test_stray_end();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
